// File: rtl/dmem_ctrl_pkg.sv
// Shared types, funct3 encodings and lane helpers for the RV32I data memory.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int DMEM_MEM_SIZE = 1024;

  function automatic mem_size_e size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  return {24'b0, sh[7:0]};
      F3_LHU:  return {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dmem_bank
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_MEM_SIZE
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data memory controller: request/response FSM, access checks and lane steering.
//
// state   | meaning
// ST_IDLE | ready for a request
// ST_WAIT | counting wait states before the memory access
// ST_RESP | response presented until rsp_ready_i
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = DMEM_MEM_SIZE,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;
  localparam logic [3:0]  CNT_INIT   = 4'(WAIT_STATES - 1);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept, access, in_idle;
  logic              cur_we, cur_err;
  logic [2:0]        cur_f3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  mem_size_e         cur_size;
  logic [3:0]        byteen, bank_be;
  logic [31:0]       wlane, bank_rdata;
  logic              bank_en;

  assign in_idle     = (state_q == ST_IDLE);
  assign req_ready_o = in_idle;
  assign accept      = req_valid_i & req_ready_o;

  // With no wait states the access happens on the accept edge, before capture.
  assign cur_we    = in_idle ? req_we_i     : we_q;
  assign cur_f3    = in_idle ? req_funct3_i : f3_q;
  assign cur_addr  = in_idle ? req_addr_i   : addr_q;
  assign cur_wdata = in_idle ? req_wdata_i  : wdata_q;

  always_comb begin
    cur_size = size_of(cur_f3);
    cur_err  = !funct3_legal(cur_we, cur_f3) ||
               (64'(cur_addr) >= BYTE_LIMIT) ||
               ((cur_size == MEM_H) && cur_addr[0]) ||
               ((cur_size == MEM_W) && (cur_addr[1:0] != 2'b00));
    byteen   = 4'b1111;
    wlane    = cur_wdata;
    case (cur_size)
      MEM_B: begin
        byteen = 4'b0001 << cur_addr[1:0];
        wlane  = {4{cur_wdata[7:0]}};
      end
      MEM_H: begin
        byteen = 4'b0011 << cur_addr[1:0];
        wlane  = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset on the access edge must not let a pending store reach the RAM.
  assign bank_en = access & ~cur_err & rst_n_i;
  assign bank_be = cur_we ? byteen : 4'b0000;

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk_i   (clk_i),
    .en_i    (bank_en),
    .be_i    (bank_be),
    .idx_i   (cur_addr[IDX_W+1:2]),
    .wdata_i (wlane),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (access) err_q <= cur_err;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ?
                       load_extract(f3_q, addr_q[1:0], bank_rdata) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 3 wait states) against a byte-array model.
module tb_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int BYTES = DEPTH * 4;

  logic             clk;
  logic [1:0]       rst_n;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bmem [2][BYTES];

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: byte-addressed little-endian memory, errors from the access rules.
  task automatic model(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] ed, output logic ee);
    int     n;
    bit     legal;
    longint v;
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 < 3'd6));
    ee    = !legal || ((addr % n) != 0) || (addr >= BYTES);
    ed    = 32'd0;
    if (!ee) begin
      if (we) begin
        for (int i = 0; i < n; i++) bmem[d][addr + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(bmem[d][addr + i]) << (8 * i));
        if (!f3[2] && (n < 4) && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        ed = v[31:0];
      end
    end
  endtask

  task automatic run(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] exp_d;
    logic        exp_e;
    int          guard, lat;
    model(d, we, f3, addr, wdata, exp_d, exp_e);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = addr; req_wdata[d] = wdata;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin @(negedge clk); guard++; end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[d] && lat < 40);
    chk("latency", 32'(lat), 32'(1 + ws(d)));
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("rsp_rdata", rsp_rdata[d], exp_d);
      chk("rsp_err", 32'(rsp_err[d]), 32'(exp_e));
      chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      if (i < hold) @(negedge clk);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
    chk("req_ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er, we;
    logic [2:0]  f3;
    int          p;

    rst_n = 2'b00; req_valid = '0; req_we = '0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
    end
    rst_n = 2'b11;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        run(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, rd, er);

    run(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);
    run(0, 1'b1, 3'b000, 32'h11, 32'h000000AA, 0, rd, er);
    run(0, 1'b0, 3'b000, 32'h11, 32'h0, 0, rd, er);
    chk("lb_sext", rd, 32'hFFFFFFAA);
    run(0, 1'b0, 3'b100, 32'h11, 32'h0, 0, rd, er);
    chk("lbu_zext", rd, 32'h000000AA);
    run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw_after_sb", rd, 32'hDEADAAEF);
    run(0, 1'b1, 3'b010, 32'h10, 32'h80010000, 0, rd, er);
    run(0, 1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    chk("lh_sext", rd, 32'hFFFF8001);
    run(0, 1'b0, 3'b101, 32'h12, 32'h0, 0, rd, er);
    chk("lhu_zext", rd, 32'h00008001);
    run(0, 1'b0, 3'b010, 32'h13, 32'h0, 0, rd, er);
    chk("lw_misaligned_err", 32'(er), 32'd1);
    run(0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF, 0, rd, er);
    chk("sh_misaligned_err", 32'(er), 32'd1);
    run(0, 1'b0, 3'b010, 32'(BYTES), 32'h0, 0, rd, er);
    chk("lw_range_err", 32'(er), 32'd1);
    chk("lw_range_rdata", rd, 32'd0);
    run(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw_unchanged", rd, 32'h80010000);

    run(1, 1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);

    run(1, 1'b1, 3'b010, 32'h20, 32'h0, 0, rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("rst_wait_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready[1]), 32'd1);
    rst_n[1] = 1'b1;
    run(1, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    chk("rst_no_write", rd, 32'h00000000);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 60; k++) begin
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0) begin
          if (we) f3 = 3'($urandom_range(0, 2));
          else begin
            p  = $urandom_range(0, 4);
            f3 = (p < 3) ? 3'(p) : 3'(p + 1);
          end
        end else begin
          f3 = 3'($urandom_range(0, 7));
        end
        a = 32'($urandom_range(0, BYTES + 31));
        if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
        run(d, we, f3, a, $urandom, $urandom_range(0, 2), rd, er);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
